encrypt_pipe_rotate_scramble: RTL and testbench

ENCRYPT_PIPE_ROTATE_SCRAMBLE -- requirements
Module: encrypt_pipe_rotate_scramble

---
 rtl/encrypt_config.sv | 36 +++
 rtl/encrypt_lane_rotate.sv | 33 +++
 rtl/encrypt_pipe_rotate_scramble.sv | 112 +++++++++++
 tb/tb_encrypt_pipe_rotate_scramble.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encrypt_config.sv
// Shared constants, lane payload type and bit-permutation helpers for the
// rotate/scramble cipher pipeline.
package encrypt_config;

  localparam int unsigned ALPHA_SIZE = 26;
  localparam int unsigned CHAR_W     = 8;
  localparam int unsigned SHIFT_W    = 5;
  localparam int unsigned PERM_IDX_W = 3;

  typedef logic [CHAR_W-1:0] lane_t;

  // Scrambled bit j takes rotated bit PERM[j]; element 0 is the rightmost entry.
  localparam logic [CHAR_W-1:0][PERM_IDX_W-1:0] PERM =
    {3'd4, 3'd3, 3'd6, 3'd1, 3'd7, 3'd0, 3'd5, 3'd2};

  // PERM_INV[k] is the scrambled bit that carries rotated bit k.
  localparam logic [CHAR_W-1:0][PERM_IDX_W-1:0] PERM_INV =
    {3'd3, 3'd5, 3'd1, 3'd7, 3'd6, 3'd0, 3'd4, 3'd2};

  function automatic lane_t scramble(input lane_t r);
    lane_t o;
    for (int j = 0; j < int'(CHAR_W); j++) begin
      o[PERM_IDX_W'(j)] = r[PERM[PERM_IDX_W'(j)]];
    end
    return o;
  endfunction

  function automatic lane_t unscramble(input lane_t s);
    lane_t o;
    for (int k = 0; k < int'(CHAR_W); k++) begin
      o[PERM_IDX_W'(k)] = s[PERM_INV[PERM_IDX_W'(k)]];
    end
    return o;
  endfunction

endpackage

// File: rtl/encrypt_lane_rotate.sv
// One-lane letter classifier and Caesar rotation; decrypt rotates by the
// complementary amount so both directions share one adder.
module encrypt_lane_rotate
  import encrypt_config::*;
(
  input  logic [7:0] char_in,
  input  logic [4:0] shift,
  input  logic       mode,
  output logic [7:0] char_out
);

  logic [SHIFT_W-1:0] amt;
  logic [5:0]         pos;

  always_comb begin
    amt      = shift;
    pos      = '0;
    char_out = char_in;
    if (!mode) begin
      amt = (shift == '0) ? '0 : SHIFT_W'(ALPHA_SIZE) - shift;
    end
    if (char_in >= 8'h41 && char_in <= 8'h5A) begin
      pos = 6'(char_in - 8'h41) + 6'(amt);
      if (pos >= 6'(ALPHA_SIZE)) pos = pos - 6'(ALPHA_SIZE);
      char_out = 8'h41 + 8'(pos);
    end else if (char_in >= 8'h61 && char_in <= 8'h7A) begin
      pos = 6'(char_in - 8'h61) + 6'(amt);
      if (pos >= 6'(ALPHA_SIZE)) pos = pos - 6'(ALPHA_SIZE);
      char_out = 8'h61 + 8'(pos);
    end
  end

endmodule

// File: rtl/encrypt_pipe_rotate_scramble.sv
// Two-stage rotate/scramble cipher pipeline with a writable key table.
// Define ENCRYPT_ROLL_KEY_EN for a rolling key pointer; otherwise all lanes use key[0].
module encrypt_pipe_rotate_scramble
  import encrypt_config::*;
#(
  parameter int unsigned LANES   = 1,
  parameter int unsigned KEY_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*LANES-1:0]         in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*LANES-1:0]         out_data,
  input  logic                       cfg_we,
  input  logic [$clog2(KEY_LEN)-1:0] cfg_idx,
  input  logic [4:0]                 cfg_shift,
  input  logic                       key_restart,
  output logic                       cfg_err
);

  localparam int unsigned IDX_W = $clog2(KEY_LEN);

  logic [KEY_LEN-1:0][SHIFT_W-1:0] key_tab;
  logic [LANES-1:0][SHIFT_W-1:0]   lane_shift;
  logic [8*LANES-1:0]              rot_data;
  logic [8*LANES-1:0]              scr_data;
  logic [8*LANES-1:0]              s1_data;
  logic                            s1_valid;
  logic                            s1_mode;
  logic                            s1_adv;
  logic                            accept;

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s1_adv);
  assign accept   = in_valid && in_ready;

  // Key table; out-of-alphabet shifts are dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_tab <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_we) begin
      if (cfg_shift <= SHIFT_W'(ALPHA_SIZE - 1)) key_tab[cfg_idx] <= cfg_shift;
      else                                       cfg_err          <= 1'b1;
    end
  end

`ifdef ENCRYPT_ROLL_KEY_EN
  logic [IDX_W-1:0] ptr;

  // Restart outranks advance; a coincident beat already used the old pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ptr <= '0;
    else if (key_restart) ptr <= '0;
    else if (accept)      ptr <= ptr + IDX_W'(LANES);
  end
`else
  logic [1:0] unused_cfg;
  assign unused_cfg = {key_restart, ^key_tab};
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] lane_in;

`ifdef ENCRYPT_ROLL_KEY_EN
    assign lane_shift[i] = key_tab[ptr + IDX_W'(i)];
`else
    assign lane_shift[i] = key_tab[0];
`endif
    assign lane_in = mode ? in_data[8*i +: 8] : unscramble(in_data[8*i +: 8]);

    encrypt_lane_rotate u_rotate (
      .char_in  (lane_in),
      .shift    (lane_shift[i]),
      .mode     (mode),
      .char_out (rot_data[8*i +: 8])
    );

    assign scr_data[8*i +: 8] = s1_mode ? scramble(s1_data[8*i +: 8]) : s1_data[8*i +: 8];
  end

  // Stage 1: rotated payload and direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_data  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_mode  <= mode;
      s1_data  <= rot_data;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: scrambled output, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) out_data <= scr_data;
    end
  end

endmodule

// File: tb/tb_encrypt_pipe_rotate_scramble.sv
// Self-checking bench: directed cipher vectors, config/reset corner cases and a
// randomized encrypt-then-decrypt chain with backpressure against a reference model.
module tb_encrypt_pipe_rotate_scramble;

  localparam int unsigned LANES   = 1;
  localparam int unsigned KEY_LEN = 4;
`ifdef ENCRYPT_ROLL_KEY_EN
  localparam bit ROLL = 1'b1;
`else
  localparam bit ROLL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = 2'd0;
  logic [4:0] cfg_shift = 5'd0;
  logic       key_restart = 1'b0;
  logic       cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  int         keys_m [KEY_LEN];
  int         ptr_m = 0;
  logic [7:0] plain_q [$];
  logic [7:0] cipher_q [$];

  encrypt_pipe_rotate_scramble #(.LANES(LANES), .KEY_LEN(KEY_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_shift   (cfg_shift),
    .key_restart (key_restart),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: Caesar shift on letters, then bit j of output = bit perm[j].
  function automatic logic [7:0] ref_rot(input logic [7:0] c, input int s);
    int v;
    v = int'(c);
    if (v >= 65 && v <= 90)  return 8'((v - 65 + s) % 26 + 65);
    if (v >= 97 && v <= 122) return 8'((v - 97 + s) % 26 + 97);
    return c;
  endfunction

  function automatic logic [7:0] ref_scr(input logic [7:0] r);
    int         perm [8] = '{2, 5, 0, 7, 1, 6, 3, 4};
    logic [7:0] o;
    for (int j = 0; j < 8; j++) o[j] = r[perm[j]];
    return o;
  endfunction

  function automatic int take_shift();
    int s;
    s = keys_m[ROLL ? ptr_m : 0];
    if (ROLL) ptr_m = (ptr_m + int'(LANES)) % int'(KEY_LEN);
    return s;
  endfunction

  task automatic cfg_write(input int idx, input int sh);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_shift = 5'(sh);
    @(negedge clk);
    cfg_we = 1'b0;
    if (sh <= 25) keys_m[idx] = sh;
  endtask

  task automatic restart();
    @(negedge clk);
    key_restart = 1'b1;
    @(negedge clk);
    key_restart = 1'b0;
    ptr_m = 0;
  endtask

  // One beat with out_ready high; lat counts edges from the accept edge to out_valid.
  task automatic send_beat(input logic m, input logic [7:0] b, output logic [7:0] got, output int lat);
    int waited;
    got = 8'h00;
    lat = -1;
    @(negedge clk);
    mode = m; in_data = b; in_valid = 1'b1; out_ready = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k + 1;
        got = out_data;
        break;
      end
    end
  endtask

  task automatic run_phase(input logic m, input int n);
    logic [7:0] src [$];
    logic [7:0] exp_q [$];
    logic [7:0] e;
    logic [7:0] held;
    logic       stalled;
    logic       acc;
    logic       xf;
    int         si;
    int         ri;
    int         cyc;
    src = m ? plain_q : cipher_q;
    restart();
    mode = m;
    si = 0; ri = 0; cyc = 0; stalled = 1'b0; held = 8'h00;
    while ((si < n || ri < n) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (si < n) && ($urandom_range(0, 4) != 0);
      in_data   = in_valid ? src[si] : 8'($urandom);
      #1;
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(held));
      end
      acc = in_valid && in_ready;
      xf  = out_valid && out_ready;
      if (xf) begin
        check("out_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(m ? "enc_beat" : "dec_roundtrip", 32'(out_data), 32'(e));
        end
        if (m) cipher_q.push_back(out_data);
        ri++;
      end
      if (acc) begin
        if (m) e = ref_scr(ref_rot(src[si], take_shift()));
        else begin
          void'(take_shift());
          e = plain_q[si];
        end
        exp_q.push_back(e);
        si++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
    end
    check("phase_in_count", 32'(si), 32'(n));
    check("phase_out_count", 32'(ri), 32'(n));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_extra_beat", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] roll_pre [5];
    logic [7:0] e;
    int         lat;
    int         r;

    for (int i = 0; i < int'(KEY_LEN); i++) keys_m[i] = 0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed vectors
    cfg_write(0, 3);
    restart();
    send_beat(1'b1, 8'h41, got, lat);
    void'(take_shift());
    check("enc_A_k3", 32'(got), 32'h21);
    check("latency", 32'(lat), 32'd2);

    cfg_write(0, 1);
    restart();
    send_beat(1'b1, 8'h7A, got, lat);
    void'(take_shift());
    check("enc_z_k1", 32'(got), 32'h26);
    restart();
    send_beat(1'b1, 8'h20, got, lat);
    void'(take_shift());
    check("enc_space", 32'(got), 32'h02);
    restart();
    send_beat(1'b0, 8'h26, got, lat);
    void'(take_shift());
    check("dec_z_k1", 32'(got), 32'h7A);
    check("dec_latency", 32'(lat), 32'd2);

    // Key write coincident with accept: beat uses the old key
    restart();
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_shift = 5'd5;
    mode = 1'b1; in_data = 8'h41; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("ready_for_cowrite", 32'(in_ready), 32'd1);
    e = ref_scr(ref_rot(8'h41, take_shift()));
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    keys_m[0] = 5;
    @(negedge clk);
    check("cowrite_old_key", 32'(out_data), 32'(e));
    check("cowrite_valid", 32'(out_valid), 32'd1);

    // Out-of-range shift is dropped and flagged
    cfg_write(0, 30);
    check("cfg_err_set", 32'(cfg_err), 32'd1);
    restart();
    send_beat(1'b1, 8'h41, got, lat);
    check("key_unchanged", 32'(got), 32'(ref_scr(ref_rot(8'h41, take_shift()))));
    cfg_write(0, 7);
    check("cfg_err_sticky", 32'(cfg_err), 32'd1);

    // Rolling key vector (all lanes on key[0] when rolling is off)
    roll_pre = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h42};
    for (int i = 0; i < 4; i++) cfg_write(i, i + 1);
    restart();
    for (int k = 0; k < 5; k++) begin
      send_beat(1'b1, 8'h41, got, lat);
      void'(take_shift());
      check("roll_AAAAA", 32'(got), 32'(ref_scr(ROLL ? roll_pre[k] : 8'h42)));
    end
    restart();
    send_beat(1'b1, 8'h41, got, lat);
    void'(take_shift());
    check("restart_A", 32'(got), 32'(ref_scr(8'h42)));

    // Randomized encrypt then decrypt chain with stalls
    for (int i = 0; i < 4; i++) cfg_write(i, int'($urandom_range(0, 25)));
    for (int k = 0; k < 500; k++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)      plain_q.push_back(8'($urandom_range(65, 90)));
      else if (r == 1) plain_q.push_back(8'($urandom_range(97, 122)));
      else             plain_q.push_back(8'($urandom));
    end
    run_phase(1'b1, 500);
    run_phase(1'b0, 500);

    // Fill both stages under backpressure, then reset mid-stream
    @(negedge clk);
    out_ready = 1'b0; mode = 1'b1; in_data = 8'h41; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_cfg_err", 32'(cfg_err), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < int'(KEY_LEN); i++) keys_m[i] = 0;
    ptr_m = 0;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    send_beat(1'b1, 8'h41, got, lat);
    void'(take_shift());
    check("postrst_keys_zero", 32'(got), 32'h24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
